// File: rtl/gmem_rd_arbiter.sv
// gmem_rd_arbiter: round-robin sharing of the gmem read channel (AR+R) among
// NUM_REQ read engines. One burst is issued at a time on AR; the issue order
// is logged in an order FIFO so that in-order R beats (single ARID) can be
// steered back to the requester that owns the burst at the FIFO head.
// Optional build macro: GMEM_RD_ARB_PERF_EN adds per-requester burst counters
// (perf_bursts) and a full-FIFO stall counter (perf_stall).
module gmem_rd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 42,
  parameter int DATA_W      = 512,
  parameter int OUTST_DEPTH = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  output logic [NUM_REQ-1:0]        req_arready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]      req_arlen,
  output logic [NUM_REQ-1:0]        req_rvalid,
  input  logic [NUM_REQ-1:0]        req_rready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_rlast,
  output logic                      m_axi_gmem_ARVALID,
  input  logic                      m_axi_gmem_ARREADY,
  output logic [ADDR_W-1:0]         m_axi_gmem_ARADDR,
  output logic [7:0]                m_axi_gmem_ARLEN,
  output logic [0:0]                m_axi_gmem_ARID,
  output logic [2:0]                m_axi_gmem_ARSIZE,
  output logic [1:0]                m_axi_gmem_ARBURST,
  output logic [0:0]                m_axi_gmem_ARLOCK,
  output logic [3:0]                m_axi_gmem_ARCACHE,
  output logic [2:0]                m_axi_gmem_ARPROT,
  output logic [3:0]                m_axi_gmem_ARQOS,
  output logic [3:0]                m_axi_gmem_ARREGION,
  input  logic                      m_axi_gmem_RVALID,
  output logic                      m_axi_gmem_RREADY,
  input  logic [DATA_W-1:0]         m_axi_gmem_RDATA,
  input  logic                      m_axi_gmem_RLAST,
  input  logic [0:0]                m_axi_gmem_RID,
  input  logic [1:0]                m_axi_gmem_RRESP,
  output logic                      rd_err
`ifdef GMEM_RD_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]     perf_bursts,
  output logic [31:0]               perf_stall
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int AW = $clog2(OUTST_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = GW + 8;

  typedef enum logic [0:0] {ST_ARB, ST_ISSUE} state_t;

  state_t                state_reg, state_next;
  logic [GW-1:0]         rr_ptr_reg, grant_reg;
  logic [ADDR_W-1:0]     ar_addr_reg;
  logic [7:0]            ar_len_reg;
  logic                  load_ar, ar_hs;
  logic                  pick_valid;
  logic [GW-1:0]         pick_idx;
  logic [GW-1:0]         rot_idx [NUM_REQ];
  logic [ADDR_W-1:0]     req_addr_arr [NUM_REQ];
  logic [7:0]            req_len_arr [NUM_REQ];

  logic [EW-1:0]         fifo_mem [OUTST_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg, count_next;
  logic                  full_reg, fifo_empty, push, pop;
  logic [EW-1:0]         head_entry;
  logic [GW-1:0]         head_owner;
  logic [7:0]            head_len;
  logic                  beat_acc;
  logic [7:0]            beat_cnt_reg;
  logic                  rd_err_reg;

  // Only one ARID is ever issued, so the returned ID carries no information.
  logic unused_rid;
  assign unused_rid = ^m_axi_gmem_RID;

  // Unpack requester fields and build the rotated search order rr_ptr, rr_ptr+1, ...
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [GW:0] sum;
    assign req_addr_arr[gi] = req_araddr[gi*ADDR_W +: ADDR_W];
    assign req_len_arr[gi]  = req_arlen[gi*8 +: 8];
    assign sum              = {1'b0, rr_ptr_reg} + (GW+1)'(gi);
    assign rot_idx[gi]      = (sum >= (GW+1)'(NUM_REQ)) ? GW'(sum - (GW+1)'(NUM_REQ))
                                                        : sum[GW-1:0];
    assign req_arready[gi]  = ar_hs && (grant_reg == GW'(gi));
  end

  // Round-robin pick: scan from the far end so the smallest rotation offset wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_arvalid[rot_idx[i]]) begin
        pick_valid = 1'b1;
        pick_idx   = rot_idx[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_reg <= ST_ARB;
    else        state_reg <= state_next;
  end

  // FSM next state: grant only when the registered full flag is clear.
  always_comb begin
    state_next = state_reg;
    load_ar    = 1'b0;
    ar_hs      = 1'b0;
    case (state_reg)
      ST_ARB: begin
        if (pick_valid && !full_reg) begin
          load_ar    = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_axi_gmem_ARREADY) begin
          ar_hs      = 1'b1;
          state_next = ST_ARB;
        end
      end
      default: state_next = ST_ARB;
    endcase
  end

  // Capture the granted request and advance the round-robin pointer on handshake.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ar_addr_reg <= '0;
      ar_len_reg  <= '0;
      grant_reg   <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      if (load_ar) begin
        ar_addr_reg <= req_addr_arr[pick_idx];
        ar_len_reg  <= req_len_arr[pick_idx];
        grant_reg   <= pick_idx;
      end
      if (ar_hs) begin
        rr_ptr_reg <= (grant_reg == GW'(NUM_REQ - 1)) ? '0 : grant_reg + GW'(1);
      end
    end
  end

  assign m_axi_gmem_ARVALID  = (state_reg == ST_ISSUE);
  assign m_axi_gmem_ARADDR   = ar_addr_reg;
  assign m_axi_gmem_ARLEN    = ar_len_reg;
  assign m_axi_gmem_ARID     = '0;
  assign m_axi_gmem_ARSIZE   = 3'($clog2(DATA_W / 8));
  assign m_axi_gmem_ARBURST  = 2'b01;
  assign m_axi_gmem_ARLOCK   = '0;
  assign m_axi_gmem_ARCACHE  = 4'b0011;
  assign m_axi_gmem_ARPROT   = '0;
  assign m_axi_gmem_ARQOS    = '0;
  assign m_axi_gmem_ARREGION = '0;

  // Order FIFO storage: {owner, len} per issued burst, head read combinationally.
  always_ff @(posedge ap_clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {grant_reg, ar_len_reg};
  end

  assign push       = ar_hs;
  assign pop        = beat_acc && m_axi_gmem_RLAST;
  assign fifo_empty = (count_reg == '0);
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign head_owner = head_entry[EW-1:8];
  assign head_len   = head_entry[7:0];

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + CW'(1);
    else if (!push && pop) count_next = count_reg - CW'(1);
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(OUTST_DEPTH));
    end
  end

  // Zero-latency R steering to the owner of the head burst.
  always_comb begin
    req_rvalid        = '0;
    m_axi_gmem_RREADY = 1'b0;
    if (!fifo_empty) begin
      req_rvalid[head_owner] = m_axi_gmem_RVALID;
      m_axi_gmem_RREADY      = req_rready[head_owner];
    end
  end

  assign req_rdata = m_axi_gmem_RDATA;
  assign req_rlast = m_axi_gmem_RLAST;
  assign beat_acc  = m_axi_gmem_RVALID && m_axi_gmem_RREADY;

  // Beat counter within the head burst and sticky error on RLAST/RRESP anomalies.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      beat_cnt_reg <= '0;
      rd_err_reg   <= 1'b0;
    end else if (beat_acc) begin
      beat_cnt_reg <= m_axi_gmem_RLAST ? 8'd0 : beat_cnt_reg + 8'd1;
      if ((m_axi_gmem_RLAST != (beat_cnt_reg == head_len)) || (m_axi_gmem_RRESP != 2'b00)) begin
        rd_err_reg <= 1'b1;
      end
    end
  end

  assign rd_err = rd_err_reg;

`ifdef GMEM_RD_ARB_PERF_EN
  logic [31:0] perf_stall_reg;

  // Per-requester granted-burst counters.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [31:0] bursts_reg;
    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst)               bursts_reg <= '0;
      else if (req_arready[gi]) bursts_reg <= bursts_reg + 32'd1;
    end
    assign perf_bursts[gi*32 +: 32] = bursts_reg;
  end

  // Cycles spent in ARB with a request pending but the order FIFO full.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) perf_stall_reg <= '0;
    else if ((state_reg == ST_ARB) && (|req_arvalid) && full_reg) perf_stall_reg <= perf_stall_reg + 32'd1;
  end

  assign perf_stall = perf_stall_reg;
`endif

endmodule
